// File: rtl/ram_burst_master_if.sv
// Burst command, write/read stream, status and RAM pin bundle.
// Modports: master = burst engine side, slave = client/RAM side.
//   cmd_*   : burst command (valid/ready)
//   wdata_* : write stream (valid/ready)
//   rdata_* : read stream (valid only)
//   busy/done/err : status
//   ram_*   : RAM control, address and data pins
interface ram_burst_master_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_len;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] wdata;
  logic              rdata_valid;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              done;
  logic              err;
  logic              ram_cs;
  logic              ram_wr;
  logic              ram_rd;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_len,
    input  wdata_valid, wdata, ram_dout,
    output cmd_ready, wdata_ready,
    output rdata_valid, rdata,
    output busy, done, err,
    output ram_cs, ram_wr, ram_rd,
    output ram_addr, ram_din
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_len,
    output wdata_valid, wdata, ram_dout,
    input  cmd_ready, wdata_ready,
    input  rdata_valid, rdata,
    input  busy, done, err,
    input  ram_cs, ram_wr, ram_rd,
    input  ram_addr, ram_din
  );
endinterface

// File: rtl/ram_burst_master.sv
// Burst initiator for the dual-port RAM: write/read bursts
// of cmd_len+1 beats at consecutive (wrapping) addresses.
// Ports: clk, rst (sync, active high), bus (master modport of
//   ram_burst_master_if: cmd, wdata, rdata, status, ram pins).
// Option: RAM_BOUND_CHECK_EN rejects bursts crossing the top
//   address with a one-cycle err pulse; otherwise err = 0.
module ram_burst_master #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4,
  parameter int RD_LAT = 1
) (
  input logic clk,
  input logic rst,
  ram_burst_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr_ctr;
  logic [ADDR_W-1:0] r_beat_ctr;
  logic              r_ram_cs;
  logic              r_ram_wr;
  logic              r_ram_rd;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_din;
  logic [RD_LAT-1:0] r_vpipe;
  logic              r_rdata_valid;
  logic [DATA_W-1:0] r_rdata;
  logic              w_oob;
  logic              w_last;
  logic [RD_LAT-1:0] w_vin;

`ifdef RAM_BOUND_CHECK_EN
  logic              r_err;
  logic [ADDR_W:0]   w_end;

  // carry out of addr+len means the burst runs past the top
  assign w_end = {1'b0, bus.cmd_addr} + {1'b0, bus.cmd_len};
  assign w_oob = w_end[ADDR_W];
  assign bus.err = r_err;
`else
  assign w_oob = 1'b0;
  assign bus.err = 1'b0;
`endif

  assign w_last = (r_beat_ctr == '0);
  assign w_vin  = RD_LAT'(r_ram_rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_addr_ctr    <= '0;
      r_beat_ctr    <= '0;
      r_ram_cs      <= 1'b0;
      r_ram_wr      <= 1'b0;
      r_ram_rd      <= 1'b0;
      r_ram_addr    <= '0;
      r_ram_din     <= '0;
      r_vpipe       <= '0;
      r_rdata_valid <= 1'b0;
      r_rdata       <= '0;
`ifdef RAM_BOUND_CHECK_EN
      r_err         <= 1'b0;
`endif
    end else begin
      // read-valid shadow of ram_rd; the tap at RD_LAT-1
      // marks the cycle where ram_dout holds a beat
      r_vpipe       <= (r_vpipe << 1) | w_vin;
      r_rdata_valid <= r_vpipe[RD_LAT-1];
      if (r_vpipe[RD_LAT-1])
        r_rdata <= bus.ram_dout;
`ifdef RAM_BOUND_CHECK_EN
      r_err <= 1'b0;
`endif
      unique case (r_state)
        S_IDLE: begin
          r_ram_cs <= 1'b0;
          r_ram_wr <= 1'b0;
          r_ram_rd <= 1'b0;
          if (bus.cmd_valid) begin
            if (w_oob) begin
`ifdef RAM_BOUND_CHECK_EN
              r_err <= 1'b1;
`endif
            end else begin
              r_addr_ctr <= bus.cmd_addr;
              r_beat_ctr <= bus.cmd_len;
              r_state    <= bus.cmd_wr ? S_WRITE : S_READ;
            end
          end
        end
        S_WRITE: begin
          if (bus.wdata_valid) begin
            r_ram_cs   <= 1'b1;
            r_ram_wr   <= 1'b1;
            r_ram_addr <= r_addr_ctr;
            r_ram_din  <= bus.wdata;
            r_addr_ctr <= r_addr_ctr + 1'b1;
            r_beat_ctr <= r_beat_ctr - 1'b1;
            // DRAIN covers the cycle of the last RAM write
            if (w_last)
              r_state <= S_DRAIN;
          end else begin
            r_ram_cs <= 1'b0;
            r_ram_wr <= 1'b0;
          end
        end
        S_READ: begin
          r_ram_cs   <= 1'b1;
          r_ram_rd   <= 1'b1;
          r_ram_addr <= r_addr_ctr;
          r_addr_ctr <= r_addr_ctr + 1'b1;
          r_beat_ctr <= r_beat_ctr - 1'b1;
          if (w_last)
            r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          r_ram_cs <= 1'b0;
          r_ram_wr <= 1'b0;
          r_ram_rd <= 1'b0;
          // leave in the cycle showing the last rdata_valid
          if (!r_ram_rd && r_vpipe == '0)
            r_state <= S_DONE;
        end
        S_DONE: begin
          r_ram_cs <= 1'b0;
          r_ram_wr <= 1'b0;
          r_ram_rd <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = (r_state == S_IDLE);
  assign bus.wdata_ready = (r_state == S_WRITE);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = (r_state == S_DONE);
  assign bus.rdata_valid = r_rdata_valid;
  assign bus.rdata       = r_rdata;
  assign bus.ram_cs      = r_ram_cs;
  assign bus.ram_wr      = r_ram_wr;
  assign bus.ram_rd      = r_ram_rd;
  assign bus.ram_addr    = r_ram_addr;
  assign bus.ram_din     = r_ram_din;

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed bench for ram_burst_master with a RD_LAT=1 RAM.
// Build with +define+RAM_BOUND_CHECK_EN for the bounds case.
module tb_ram_burst_master;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ram_burst_master_if #(.ADDR_W(8), .DATA_W(4)) bus ();

  ram_burst_master #(
    .ADDR_W(8), .DATA_W(4), .RD_LAT(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [3:0] mem [256];
  always @(posedge clk) begin
    if (bus.ram_cs && bus.ram_wr)
      mem[bus.ram_addr] <= bus.ram_din;
    if (bus.ram_cs && bus.ram_rd)
      bus.ram_dout <= mem[bus.ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;
  int acc_cyc = 0;
  int first_rv = -1;
  int done_at = -1;
  int n_done = 0;
  int n_errp = 0;
  int n_rd = 0;
  int n_bad = 0;
  int n_acc = 0;
  logic [11:0] wq [$];
  logic [3:0]  rq [$];
  logic        cs_tr [32];
  logic [7:0]  ad_tr [32];

  always @(negedge clk) begin
    int rel;
    rel = cyc - acc_cyc;
    if (bus.ram_cs && bus.ram_wr)
      wq.push_back({bus.ram_addr, bus.ram_din});
    if (bus.ram_cs && bus.ram_rd) n_rd++;
    if (bus.rdata_valid) begin
      rq.push_back(bus.rdata);
      if (first_rv < 0) first_rv = rel;
    end
    if (bus.done) begin
      n_done++;
      done_at = rel;
    end
    if (bus.err) n_errp++;
    if ((bus.ram_wr && bus.ram_rd) ||
        (bus.ram_cs != (bus.ram_wr || bus.ram_rd)))
      n_bad++;
    if (bus.cmd_valid && bus.cmd_ready) n_acc++;
    if (rel >= 0 && rel < 32) begin
      cs_tr[rel] = bus.ram_cs;
      ad_tr[rel] = bus.ram_addr;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic wr,
                          input logic [7:0] a,
                          input logic [7:0] l);
    int t = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = wr;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    while (!bus.cmd_ready && t < 100) begin
      tick();
      t++;
    end
    chk("cmd_accept", 32'(t < 100), 1);
    acc_cyc  = cyc + 1;
    first_rv = -1;
    done_at  = -1;
    n_rd     = 0;
    wq.delete();
    rq.delete();
    for (int i = 0; i < 32; i++) begin
      cs_tr[i] = 1'b0;
      ad_tr[i] = '0;
    end
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic write_beat(input logic [3:0] d);
    int t = 0;
    bus.wdata_valid = 1'b1;
    bus.wdata       = d;
    while (!bus.wdata_ready && t < 50) begin
      tick();
      t++;
    end
    chk("wbeat_accept", 32'(t < 50), 1);
    tick();
    bus.wdata_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (bus.busy && t < 200) begin
      tick();
      t++;
    end
    chk("idle_timeout", 32'(t < 200), 1);
    repeat (2) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    int rel;
    int dsnap;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    bus.ram_dout    = '0;
    bus.cmd_valid   = 1'b0;
    bus.cmd_wr      = 1'b0;
    bus.cmd_addr    = '0;
    bus.cmd_len     = '0;
    bus.wdata_valid = 1'b0;
    bus.wdata       = '0;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_strobes",
        {bus.ram_cs, bus.ram_wr, bus.ram_rd}, 0);
    chk("rst_addr_din", {bus.ram_addr, bus.ram_din}, 0);
    chk("rst_status",
        {bus.done, bus.err, bus.rdata_valid}, 0);
    rst = 1'b0;
    tick();

    // write burst 01..03 <- F,E,D
    send_cmd(1'b1, 8'h01, 8'd2);
    write_beat(4'hF);
    write_beat(4'hE);
    write_beat(4'hD);
    wait_idle();
    chk("wr_count", wq.size(), 3);
    chk("wr_beat0", wq[0], 12'h01F);
    chk("wr_beat1", wq[1], 12'h02E);
    chk("wr_beat2", wq[2], 12'h03D);
    chk("wr_done_cnt", n_done, 1);
    chk("wr_done_at", done_at, 4);

    // read back
    send_cmd(1'b0, 8'h01, 8'd2);
    wait_idle();
    chk("rd_count", rq.size(), 3);
    chk("rd_beat0", rq[0], 4'hF);
    chk("rd_beat1", rq[1], 4'hE);
    chk("rd_beat2", rq[2], 4'hD);
    chk("rd_first_lat", first_rv, 3);
    chk("rd_done_at", done_at, 6);
    chk("rd_done_cnt", n_done, 2);

    // single-beat write latency
    send_cmd(1'b1, 8'h80, 8'd0);
    write_beat(4'hA);
    wait_idle();
    chk("one_count", wq.size(), 1);
    chk("one_beat", wq[0], 12'h80A);
    chk("one_done_at", done_at, 2);

    // stalled write: two idle cycles before the third beat
    send_cmd(1'b1, 8'h01, 8'd2);
    write_beat(4'h7);
    write_beat(4'h8);
    repeat (2) tick();
    write_beat(4'h9);
    wait_idle();
    chk("st_count", wq.size(), 3);
    chk("st_beat2", wq[2], 12'h039);
    chk("st_cs3", cs_tr[3], 0);
    chk("st_cs4", cs_tr[4], 0);
    chk("st_addr3", ad_tr[3], 8'h02);
    chk("st_addr4", ad_tr[4], 8'h02);
    chk("st_cs5", cs_tr[5], 1);
    chk("st_addr5", ad_tr[5], 8'h03);
    chk("st_mem3", mem[3], 4'h9);

    // burst ending exactly at the top address
    n_errp = 0;
    send_cmd(1'b1, 8'hFE, 8'd1);
    write_beat(4'h1);
    write_beat(4'h2);
    wait_idle();
    chk("top_count", wq.size(), 2);
    chk("top_beat1", wq[1], 12'hFF2);
    chk("top_err", n_errp, 0);

    // burst crossing the top address
    dsnap = n_done;
`ifdef RAM_BOUND_CHECK_EN
    send_cmd(1'b1, 8'hFE, 8'd3);
    repeat (4) tick();
    chk("bnd_writes", wq.size(), 0);
    chk("bnd_err", n_errp, 1);
    chk("bnd_done", n_done, dsnap);
    chk("bnd_ready", bus.cmd_ready, 1);
`else
    send_cmd(1'b1, 8'hFE, 8'd3);
    write_beat(4'h1);
    write_beat(4'h2);
    write_beat(4'h3);
    write_beat(4'h4);
    wait_idle();
    chk("wrap_count", wq.size(), 4);
    chk("wrap_beat0", wq[0], 12'hFE1);
    chk("wrap_beat1", wq[1], 12'hFF2);
    chk("wrap_beat2", wq[2], 12'h003);
    chk("wrap_beat3", wq[3], 12'h014);
    chk("wrap_err", n_errp, 0);
    chk("wrap_done", n_done, dsnap + 1);
`endif

    // reset in the middle of a read burst
    send_cmd(1'b0, 8'h20, 8'd7);
    t = 0;
    while (n_rd < 3 && t < 50) begin
      tick();
      t++;
    end
    chk("mid_reads", n_rd, 3);
    rst = 1'b1;
    rq.delete();
    dsnap = n_done;
    tick();
    chk("mid_strobes",
        {bus.ram_cs, bus.ram_wr, bus.ram_rd}, 0);
    chk("mid_busy", bus.busy, 0);
    rst = 1'b0;
    repeat (8) tick();
    chk("mid_no_rdata", rq.size(), 0);
    chk("mid_no_done", n_done, dsnap);
    chk("mid_ready", bus.cmd_ready, 1);

    // second command held while a write burst runs
    send_cmd(1'b1, 8'h40, 8'd1);
    n_acc = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = 1'b0;
    bus.cmd_addr  = 8'h40;
    bus.cmd_len   = 8'd1;
    write_beat(4'h5);
    write_beat(4'h6);
    t = 0;
    while (!bus.cmd_ready && t < 50) begin
      tick();
      t++;
    end
    rel = cyc - acc_cyc;
    chk("busy_done_at", done_at, 3);
    chk("busy_ready_at", rel, 4);
    acc_cyc  = cyc + 1;
    first_rv = -1;
    rq.delete();
    tick();
    bus.cmd_valid = 1'b0;
    wait_idle();
    chk("busy_accepts", n_acc, 1);
    chk("busy_rd_count", rq.size(), 2);
    chk("busy_rd0", rq[0], 4'h5);
    chk("busy_rd1", rq[1], 4'h6);

    chk("strobe_rules", n_bad, 0);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
